// File: rtl/cache_tag_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_tag_ctrl_if
// Bundles the three buses the cache tag controller talks on:
//   CPU side    : cpu_req_valid/cpu_req_ready/cpu_addr in,
//                 cpu_rsp_valid/cpu_rsp_hit back
//   memory side : mem_req_valid/mem_req_ready/mem_req_addr line request,
//                 mem_fill_done pulse when the line has arrived
//   tag array   : tag_write_enable, tag_read_enable, tag_adress,
//                 tag_data_in out to the array, tag_data_out back from it
// Modports:
//   slave  - the controller (answers CPU requests, drives memory/tag array)
//   master - the environment (CPU, memory and the tag array itself)
// ---------------------------------------------------------------------------
interface cache_tag_ctrl_if #(
   parameter int bitsDirect = 10,
   parameter int bitsTag    = 36,
   parameter int bitsOffset = 2
);
   localparam int ADDR_W = bitsTag + bitsDirect + bitsOffset;

   logic                         cpu_req_valid;
   logic                         cpu_req_ready;
   logic [ADDR_W-1:0]            cpu_addr;
   logic                         cpu_rsp_valid;
   logic                         cpu_rsp_hit;

   logic                         mem_req_valid;
   logic                         mem_req_ready;
   logic [bitsTag+bitsDirect-1:0] mem_req_addr;
   logic                         mem_fill_done;

   logic                         tag_write_enable;
   logic                         tag_read_enable;
   logic [bitsDirect-1:0]        tag_adress;
   logic [bitsTag:0]             tag_data_in;
   logic [bitsTag:0]             tag_data_out;

   modport slave (
      input  cpu_req_valid, cpu_addr, mem_req_ready, mem_fill_done, tag_data_out,
      output cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit,
             mem_req_valid, mem_req_addr,
             tag_write_enable, tag_read_enable, tag_adress, tag_data_in
   );

   modport master (
      output cpu_req_valid, cpu_addr, mem_req_ready, mem_fill_done, tag_data_out,
      input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit,
             mem_req_valid, mem_req_addr,
             tag_write_enable, tag_read_enable, tag_adress, tag_data_in
   );
endinterface

// File: rtl/cache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// cache_tag_ctrl
// Lookup/fill controller for a direct-mapped cache tag array. Takes one CPU
// lookup at a time, reads the stored {valid, tag} line, and on a miss asks
// memory for the line, waits for the fill and writes {1, tag} back before
// answering the CPU with hit/miss.
//
// Ports:
//   clk        - rising-edge clock
//   gen_reset  - asynchronous active-high reset (shared with the tag array)
//   bus        - cache_tag_ctrl_if.slave: CPU, memory and tag array signals
//   hit_count  - (CACHE_STATS_EN only) saturating count of hit responses
//   miss_count - (CACHE_STATS_EN only) saturating count of miss responses
//
// Optional feature macro: CACHE_STATS_EN adds the two statistics counters.
// ---------------------------------------------------------------------------
module cache_tag_ctrl #(
   parameter int bitsDirect = 10,
   parameter int bitsTag    = 36,
   parameter int bitsOffset = 2
) (
   input  logic                  clk,
   input  logic                  gen_reset,
   cache_tag_ctrl_if.slave       bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int ADDR_W = bitsTag + bitsDirect + bitsOffset;
   localparam int LINE_W = bitsTag + bitsDirect;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] READ      = 3'd1;
   localparam logic [2:0] COMPARE   = 3'd2;
   localparam logic [2:0] MISS_REQ  = 3'd3;
   localparam logic [2:0] MISS_WAIT = 3'd4;
   localparam logic [2:0] FILL      = 3'd5;
   localparam logic [2:0] RESP      = 3'd6;

   logic [2:0]            state;
   logic [LINE_W-1:0]     line_addr;
   logic                  hit_flag;
   logic [bitsTag-1:0]    tag;
   logic [bitsDirect-1:0] index;

   // The byte offset is dropped when latching; only {tag, index} matter.
   assign tag   = line_addr[LINE_W-1:bitsDirect];
   assign index = line_addr[bitsDirect-1:0];

   // Main FSM. The tag compare only looks at tag_data_out in COMPARE, the
   // one cycle where the registered array output is known to be valid.
   always_ff @(posedge clk or posedge gen_reset) begin
      if (gen_reset) begin
         state     <= IDLE;
         line_addr <= '0;
         hit_flag  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cpu_req_valid) begin
                  line_addr <= bus.cpu_addr[ADDR_W-1:bitsOffset];
                  state     <= READ;
               end
            end
            READ: state <= COMPARE;
            COMPARE: begin
               if (bus.tag_data_out[bitsTag] &&
                   (bus.tag_data_out[bitsTag-1:0] == tag)) begin
                  hit_flag <= 1'b1;
                  state    <= RESP;
               end else begin
                  state    <= MISS_REQ;
               end
            end
            MISS_REQ: begin
               if (bus.mem_req_ready) state <= MISS_WAIT;
            end
            MISS_WAIT: begin
               if (bus.mem_fill_done) state <= FILL;
            end
            FILL: begin
               hit_flag <= 1'b0;
               state    <= RESP;
            end
            RESP: begin
               hit_flag <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are a pure decode of the state and the latched address, so a
   // reset drops every strobe immediately without waiting for an edge.
   always_comb begin
      bus.cpu_req_ready    = 1'b0;
      bus.cpu_rsp_valid    = 1'b0;
      bus.cpu_rsp_hit      = 1'b0;
      bus.mem_req_valid    = 1'b0;
      bus.mem_req_addr     = '0;
      bus.tag_write_enable = 1'b0;
      bus.tag_read_enable  = 1'b0;
      bus.tag_adress       = '0;
      bus.tag_data_in      = '0;
      case (state)
         IDLE: bus.cpu_req_ready = 1'b1;
         READ, COMPARE: begin
            bus.tag_read_enable = 1'b1;
            bus.tag_adress      = index;
         end
         MISS_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = line_addr;
         end
         FILL: begin
            bus.tag_write_enable = 1'b1;
            bus.tag_adress       = index;
            bus.tag_data_in      = {1'b1, tag};
         end
         RESP: begin
            bus.cpu_rsp_valid = 1'b1;
            bus.cpu_rsp_hit   = hit_flag;
         end
         default: ;
      endcase
   end

`ifdef CACHE_STATS_EN
   // One count per response, pinned at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge gen_reset) begin
      if (gen_reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == RESP) begin
         if (hit_flag && (hit_count != 32'hFFFF_FFFF))
            hit_count <= hit_count + 32'd1;
         if (!hit_flag && (miss_count != 32'hFFFF_FFFF))
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_tag_ctrl
// Drives cache_tag_ctrl through a table of lookups against a behavioural
// 1024-line tag array, plus a hand-written reset-in-the-middle-of-a-miss
// sequence. Optional statistics counters are checked when CACHE_STATS_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_cache_tag_ctrl;

   localparam int FILL_GAP = 2;
   localparam int MAX_CYC  = 60;

   typedef struct {
      logic [47:0] addr;
      int          delay;
      bit          noise;
      bit          stray_fill;
      bit          exp_hit;
      logic [45:0] exp_line;
      logic [9:0]  exp_index;
      logic [36:0] exp_data;
      int          exp_lat;
   } vec_t;

   logic clk;
   logic gen_reset;
   int   checks;
   int   errors;
   int   exp_hits;
   int   exp_misses;
   vec_t vecs [11];

   cache_tag_ctrl_if #(.bitsDirect(10), .bitsTag(36), .bitsOffset(2)) bus ();

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   cache_tag_ctrl #(.bitsDirect(10), .bitsTag(36), .bitsOffset(2)) dut (
      .clk        (clk),
      .gen_reset  (gen_reset),
      .bus        (bus)
`ifdef CACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   // Behavioural tag array: registered read, cleared by the shared reset.
   logic [36:0] tag_mem [0:1023];
   always @(posedge clk or posedge gen_reset) begin
      if (gen_reset) begin
         for (int i = 0; i < 1024; i++) tag_mem[i] <= '0;
         bus.tag_data_out <= '0;
      end else begin
         if (bus.tag_write_enable) tag_mem[bus.tag_adress] <= bus.tag_data_in;
         if (bus.tag_read_enable)  bus.tag_data_out <= tag_mem[bus.tag_adress];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Runs one full lookup and plays CPU + memory around it.
   task automatic applyStimulus(input vec_t v, input string nm);
      int          stall;
      int          hs_cyc;
      int          rsp_cyc;
      int          rsp_cnt;
      int          wr_cnt;
      bit          done;
      bit          mem_seen;
      bit          line_moved;
      bit          busy_bad;
      bit          both_bad;
      logic        rsp_hit;
      logic [36:0] wr_data;
      logic [9:0]  wr_idx;
      logic [45:0] first_line;
      stall = 0; hs_cyc = -1; rsp_cyc = -1; rsp_cnt = 0; wr_cnt = 0;
      done = 0; mem_seen = 0; line_moved = 0; busy_bad = 0; both_bad = 0;
      rsp_hit = 1'b0; wr_data = '0; wr_idx = '0; first_line = '0;

      @(negedge clk);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr      = v.addr;
      for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
         @(negedge clk);
         bus.cpu_req_valid = 1'b0;
         bus.mem_fill_done = 1'b0;
         bus.mem_req_ready = 1'b0;
         if (rsp_cnt > 0 && cyc == rsp_cyc + 1) begin
            checkOutput({nm, "_ready_back"}, bus.cpu_req_ready, 1'b1);
            checkOutput({nm, "_rsp_one_cycle"}, bus.cpu_rsp_valid, 1'b0);
            done = 1;
            break;
         end
         if (cyc == 1) begin
            checkOutput({nm, "_read_en"}, bus.tag_read_enable, 1'b1);
            checkOutput({nm, "_read_idx"}, bus.tag_adress, v.exp_index);
         end
         if (bus.cpu_req_ready) busy_bad = 1;
         if (bus.tag_read_enable && bus.tag_write_enable) both_bad = 1;
         if (bus.mem_req_valid) begin
            if (!mem_seen) first_line = bus.mem_req_addr;
            else if (bus.mem_req_addr !== first_line) line_moved = 1;
            mem_seen = 1;
            if (stall >= v.delay) begin
               bus.mem_req_ready = 1'b1;
               hs_cyc = cyc;
            end else begin
               stall++;
            end
         end
         if (hs_cyc > 0 && cyc == hs_cyc + 1 + FILL_GAP) bus.mem_fill_done = 1'b1;
         if (v.stray_fill && cyc == 2) bus.mem_fill_done = 1'b1;
         if (v.noise) begin
            bus.cpu_req_valid = (cyc % 2 == 0);
            bus.cpu_addr      = 48'h0000_0000_9999;
         end
         if (bus.tag_write_enable) begin
            wr_cnt++;
            wr_data = bus.tag_data_in;
            wr_idx  = bus.tag_adress;
         end
         if (bus.cpu_rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_hit = bus.cpu_rsp_hit;
         end
      end
      bus.cpu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.mem_fill_done = 1'b0;

      checkOutput({nm, "_finished"}, done, 1'b1);
      checkOutput({nm, "_rsp_count"}, rsp_cnt, 1);
      checkOutput({nm, "_rsp_hit"}, rsp_hit, v.exp_hit);
      checkOutput({nm, "_latency"}, rsp_cyc, v.exp_lat);
      checkOutput({nm, "_mem_req_seen"}, mem_seen, !v.exp_hit);
      checkOutput({nm, "_busy_ready"}, busy_bad, 1'b0);
      checkOutput({nm, "_enable_excl"}, both_bad, 1'b0);
      if (v.exp_hit) begin
         checkOutput({nm, "_no_write"}, wr_cnt, 0);
         exp_hits++;
      end else begin
         checkOutput({nm, "_mem_addr"}, first_line, v.exp_line);
         checkOutput({nm, "_mem_addr_stable"}, line_moved, 1'b0);
         checkOutput({nm, "_write_count"}, wr_cnt, 1);
         checkOutput({nm, "_write_data"}, wr_data, v.exp_data);
         checkOutput({nm, "_write_idx"}, wr_idx, v.exp_index);
         exp_misses++;
      end
   endtask

   task automatic checkIdleOutputs(input string nm);
      checkOutput({nm, "_ready"}, bus.cpu_req_ready, 1'b1);
      checkOutput({nm, "_rsp_valid"}, bus.cpu_rsp_valid, 1'b0);
      checkOutput({nm, "_mem_valid"}, bus.mem_req_valid, 1'b0);
      checkOutput({nm, "_mem_addr"}, bus.mem_req_addr, 46'h0);
      checkOutput({nm, "_read_en"}, bus.tag_read_enable, 1'b0);
      checkOutput({nm, "_write_en"}, bus.tag_write_enable, 1'b0);
      checkOutput({nm, "_adress"}, bus.tag_adress, 10'h0);
      checkOutput({nm, "_data_in"}, bus.tag_data_in, 37'h0);
   endtask

   initial begin
      bit entered_wait;
      checks = 0; errors = 0; exp_hits = 0; exp_misses = 0;
      entered_wait = 0;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_addr      = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_fill_done = 1'b0;

      //             addr                   dly noise stray hit line            idx     data                  lat
      vecs[0]  = '{48'h0000_0000_1234,  0, 0, 0, 1'b0, 46'h000_0000_048D, 10'h08D, {1'b1, 36'h1},          8};
      vecs[1]  = '{48'h0000_0000_1234,  0, 0, 1, 1'b1, 46'h0,             10'h08D, 37'h0,                   3};
      vecs[2]  = '{48'h0000_0000_5234,  0, 0, 0, 1'b0, 46'h000_0000_148D, 10'h08D, {1'b1, 36'h5},          8};
      vecs[3]  = '{48'h0000_0000_1234,  5, 1, 0, 1'b0, 46'h000_0000_048D, 10'h08D, {1'b1, 36'h1},         13};
      vecs[4]  = '{48'h0000_0000_0000,  0, 0, 0, 1'b0, 46'h0,             10'h000, {1'b1, 36'h0},          8};
      vecs[5]  = '{48'h0000_0000_0003,  0, 0, 0, 1'b1, 46'h0,             10'h000, 37'h0,                   3};
      vecs[6]  = '{48'h0000_00AB_CFFF,  0, 0, 0, 1'b0, 46'h000_002A_F3FF, 10'h3FF, {1'b1, 36'hABC},        8};
      vecs[7]  = '{48'h0000_00AB_CFFD,  0, 0, 0, 1'b1, 46'h0,             10'h3FF, 37'h0,                   3};
      vecs[8]  = '{48'hFFFF_FFFF_FFFC,  1, 0, 0, 1'b0, 46'h3FFF_FFFF_FFFF, 10'h3FF, {1'b1, 36'hF_FFFF_FFFF}, 9};
      vecs[9]  = '{48'h0000_00AB_CFFC,  0, 0, 0, 1'b0, 46'h000_002A_F3FF, 10'h3FF, {1'b1, 36'hABC},        8};
      vecs[10] = '{48'h0000_0000_1234,  0, 0, 0, 1'b1, 46'h0,             10'h08D, 37'h0,                   3};

      gen_reset = 1'b1;
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
      gen_reset = 1'b0;
      @(negedge clk);
      checkIdleOutputs("post_reset");

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

`ifdef CACHE_STATS_EN
      checkOutput("stats_hits", hit_count, exp_hits);
      checkOutput("stats_misses", miss_count, exp_misses);
`endif

      // Reset while waiting for the fill: everything drops at once.
      @(negedge clk);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr      = 48'h0000_0000_5234;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         bus.cpu_req_valid = 1'b0;
         bus.mem_req_ready = 1'b0;
         if (bus.mem_req_valid) bus.mem_req_ready = 1'b1;
         else if (cyc > 3) begin
            entered_wait = 1;
            break;
         end
      end
      bus.mem_req_ready = 1'b0;
      checkOutput("rst_reached_wait", entered_wait, 1'b1);
      @(posedge clk);
      #2 gen_reset = 1'b1;
      #1;
      checkIdleOutputs("mid_reset");
      @(negedge clk);
      gen_reset = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         bus.mem_fill_done = (cyc == 0);
         @(negedge clk);
         checkOutput($sformatf("after_rst%0d_no_rsp", cyc), bus.cpu_rsp_valid, 1'b0);
         checkOutput($sformatf("after_rst%0d_ready", cyc), bus.cpu_req_ready, 1'b1);
      end
      bus.mem_fill_done = 1'b0;
`ifdef CACHE_STATS_EN
      checkOutput("stats_hits_rst", hit_count, 32'd0);
      checkOutput("stats_misses_rst", miss_count, 32'd0);
      exp_hits = 0; exp_misses = 0;
`endif
      applyStimulus(vecs[0], "post_rst_miss");
`ifdef CACHE_STATS_EN
      checkOutput("stats_misses_final", miss_count, exp_misses);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
